osc_div: RTL and testbench

OSC_DIV -- requirements
Module: osc_div

---
 rtl/osc_div.sv | 114 +++++++++++
 tb/tb_osc_div.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/osc_div.sv
// Restoring unsigned divider, one quotient bit per enabled clock (IDLE/CALC/DONE).
// Define OSC_DIV_ZERO_FAST_EN to short-circuit a zero divisor straight to DONE with div_zero set.
module osc_div #(
  parameter int WIDTH = 16
) (
  input  logic             MHz10,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
`ifdef OSC_DIV_ZERO_FAST_EN
  logic             dz_q, dz_d;
`endif

  // The shifted partial remainder needs WIDTH+1 bits; when it is >= divisor the
  // true difference fits in WIDTH bits, so a WIDTH-bit subtract is exact.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_q});
  assign diff   = rem_sh[WIDTH-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
`ifdef OSC_DIV_ZERO_FAST_EN
    dz_d    = dz_q;
`endif
    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvs_d   = divisor;
            rem_d   = '0;
            quo_d   = dividend;
            cnt_d   = CW'(WIDTH - 1);
            state_d = CALC;
`ifdef OSC_DIV_ZERO_FAST_EN
            dz_d    = (divisor == '0);
            if (divisor == '0) begin
              quo_d   = '1;
              rem_d   = dividend;
              cnt_d   = '0;
              state_d = DONE;
            end
`endif
          end
        end
        CALC: begin
          rem_d = ge ? diff : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
`ifdef OSC_DIV_ZERO_FAST_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
`ifdef OSC_DIV_ZERO_FAST_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE) && en;
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef OSC_DIV_ZERO_FAST_EN
  assign div_zero  = dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_osc_div.sv
// Directed bench for osc_div (WIDTH=16): latency, back-to-back, zero divisor, start
// while busy, enable freeze and asynchronous reset mid-divide.
module tb_osc_div;
  localparam int W = 16;

  logic         MHz10 = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready, done, div_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad = 0;
  int n;

  osc_div #(.WIDTH(W)) dut (
    .MHz10(MHz10), .rst(rst), .en(en), .start(start),
    .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  always #50 MHz10 = ~MHz10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge MHz10);
    #1;
  endtask

  // Drive a request and take the accepting edge; start is dropped right after.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Edges until done is seen, bounded so a stuck design still reaches the summary.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #5 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    tick();
    rst = 1'b0;

    // 100 / 7
    issue(16'd100, 16'd7);
    chk("t1_busy", 32'(ready), 32'd0);
    wait_done(n);
    chk("t1_lat", 32'(n), 32'd16);
    chk("t1_q", 32'(quotient), 32'd14);
    chk("t1_r", 32'(remainder), 32'd2);
    chk("t1_dz", 32'(div_zero), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_ready_back", 32'(ready), 32'd1);
    tick();
    chk("t1_q_hold", 32'(quotient), 32'd14);
    chk("t1_r_hold", 32'(remainder), 32'd2);

    // 0xFFFF / 1, start held through DONE so it is taken on the first IDLE edge
    issue(16'hFFFF, 16'd1);
    wait_done(n);
    chk("t2a_lat", 32'(n), 32'd16);
    chk("t2a_q", 32'(quotient), 32'hFFFF);
    chk("t2a_r", 32'(remainder), 32'd0);
    dividend = 16'h1234;
    divisor  = 16'h0100;
    start    = 1'b1;
    tick();
    chk("t2_idle", 32'(ready), 32'd1);
    chk("t2_q_kept", 32'(quotient), 32'hFFFF);
    tick();
    start = 1'b0;
    chk("t2b_accept", 32'(ready), 32'd0);
    wait_done(n);
    chk("t2b_lat", 32'(n), 32'd16);
    chk("t2b_q", 32'(quotient), 32'h0012);
    chk("t2b_r", 32'(remainder), 32'h0034);
    tick();

    // 5 / 0
    issue(16'd5, 16'd0);
    wait_done(n);
`ifdef OSC_DIV_ZERO_FAST_EN
    chk("t3_lat", 32'(n), 32'd0);
    chk("t3_dz", 32'(div_zero), 32'd1);
`else
    chk("t3_lat", 32'(n), 32'd16);
    chk("t3_dz", 32'(div_zero), 32'd0);
`endif
    chk("t3_q", 32'(quotient), 32'hFFFF);
    chk("t3_r", 32'(remainder), 32'd5);
    tick();

    // 200 / 9 with a stray 50 / 3 request mid-divide
    issue(16'd200, 16'd9);
    tick(); tick(); tick();
    dividend = 16'd50;
    divisor  = 16'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("t4_busy", 32'(ready), 32'd0);
    wait_done(n);
    chk("t4_lat", 32'(n + 4), 32'd16);
    chk("t4_q", 32'(quotient), 32'd22);
    chk("t4_r", 32'(remainder), 32'd2);
    tick();

    // 1000 / 33 with en low for 5 cycles
    issue(16'd1000, 16'd33);
    tick(); tick(); tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_frozen_done", 32'(done), 32'd0);
    chk("t5_frozen_ready", 32'(ready), 32'd0);
    en = 1'b1;
    wait_done(n);
    chk("t5_lat", 32'(n + 9), 32'd21);
    chk("t5_q", 32'(quotient), 32'd30);
    chk("t5_r", 32'(remainder), 32'd10);
    tick();

    // Reset mid-divide, then 9 / 4
    issue(16'd60000, 16'd7);
    tick(); tick(); tick();
    #10 rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(ready), 32'd1);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_q", 32'(quotient), 32'd0);
    chk("t6_rst_r", 32'(remainder), 32'd0);
    tick();
    rst = 1'b0;
    issue(16'd9, 16'd4);
    chk("t6_accept", 32'(ready), 32'd0);
    wait_done(n);
    chk("t6_lat", 32'(n), 32'd16);
    chk("t6_q", 32'(quotient), 32'd2);
    chk("t6_r", 32'(remainder), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
